// File: rtl/decoder_scan_pkg.sv
// ============================================================================
// Module      : decoder_scan_pkg
// Description : Shared state and mode encodings for the decoder scan block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package decoder_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SINGLE = 2'd1,
        SCAN   = 2'd2
    } state_t;

    typedef enum logic {
        MODE_SINGLE = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_t;

endpackage

`default_nettype wire

// File: rtl/decoder_generic.sv
// ============================================================================
// Module      : decoder_generic
// Description : Combinational N-to-2**N one-hot decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_generic #(
    parameter int N = 2
) (
    input  logic [N-1:0]    a,
    output logic [2**N-1:0] y
);

    for (genvar i = 0; i < 2**N; i++) begin : g_dec
        assign y[i] = (a == N'(i));
    end

endmodule

`default_nettype wire

// File: rtl/decoder_scan.sv
// ============================================================================
// Module      : decoder_scan
// Description : Sequences a one-hot channel select, either one channel
//               (SINGLE) or all channels starting at a (SCAN), DWELL cycles each.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_scan
    import decoder_scan_pkg::*;
#(
    parameter int N     = 2,
    parameter int DWELL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [N-1:0]    a,
    input  logic            mode,
    input  logic            abort,
    input  logic            en,
    output logic [2**N-1:0] y,
    output logic            busy,
    output logic            done
);

    localparam int M  = 2**N;
    localparam int DW = $clog2(DWELL + 1);

    localparam logic [DW-1:0] c_dwell_one  = DW'(1);
    localparam logic [DW-1:0] c_dwell_last = DW'(DWELL);
    localparam logic [N:0]    c_chan_one   = (N+1)'(1);
    localparam logic [N:0]    c_chan_last  = (N+1)'(M);
    localparam logic [N-1:0]  c_idx_one    = N'(1);

    state_t          r_state;
    logic [N-1:0]    r_idx;
    logic [DW-1:0]   r_dwell;
    logic [N:0]      r_chan;

    state_t          w_next_state;
    logic            w_accept;
    logic            w_last_dwell;
    logic            w_last_chan;
    logic            w_done;
    logic [M-1:0]    w_onehot;

    decoder_generic #(.N(N)) u_dec (
        .a (r_idx),
        .y (w_onehot)
    );

    // r_dwell runs 1..DWELL within a channel; r_chan counts channels visited.
    always_comb begin
        w_accept     = (r_state == IDLE) && req_valid && !abort;
        w_last_dwell = (r_dwell == c_dwell_last);
        w_last_chan  = (r_state == SINGLE) || (r_chan == c_chan_last);
        w_done       = (r_state != IDLE) && w_last_dwell && w_last_chan;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = (mode_t'(mode) == MODE_SCAN) ? SCAN : SINGLE;
                end
            end
            SINGLE, SCAN: begin
                if (abort || w_done) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_dwell <= '0;
            r_chan  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_idx   <= a;
                r_dwell <= c_dwell_one;
                r_chan  <= c_chan_one;
            end else if (r_state != IDLE) begin
                if (abort || w_done) begin
                    r_idx   <= '0;
                    r_dwell <= '0;
                    r_chan  <= '0;
                end else if (w_last_dwell) begin
                    r_idx   <= r_idx + c_idx_one;
                    r_dwell <= c_dwell_one;
                    r_chan  <= r_chan + c_chan_one;
                end else begin
                    r_dwell <= r_dwell + c_dwell_one;
                end
            end
        end
    end

    // en gates only the select lines; sequencing keeps running underneath.
    always_comb begin
        req_ready = (r_state == IDLE);
        busy      = (r_state != IDLE);
        done      = w_done;
        y         = (busy && en) ? w_onehot : '0;
    end

endmodule

`default_nettype wire

// File: tb/tb_decoder_scan.sv
// ============================================================================
// Module      : tb_decoder_scan
// Description : Directed self-checking bench for decoder_scan (N=2, DWELL=1/2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decoder_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [1:0] a;
    logic       mode;
    logic       abort;
    logic       en;

    logic       rdy1, busy1, done1;
    logic [3:0] y1;
    logic       rdy2, busy2, done2;
    logic [3:0] y2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decoder_scan #(.N(2), .DWELL(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1),
        .a(a), .mode(mode), .abort(abort), .en(en),
        .y(y1), .busy(busy1), .done(done1)
    );

    decoder_scan #(.N(2), .DWELL(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy2),
        .a(a), .mode(mode), .abort(abort), .en(en),
        .y(y2), .busy(busy2), .done(done2)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        req_valid = 1'b0;
        abort     = 1'b0;
        en        = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; a = '0; mode = 1'b0; abort = 1'b0; en = 1'b1;
        repeat (2) tick();
        checks++;
        if (y1 !== 4'b0000 || busy1 !== 1'b0 || done1 !== 1'b0 || rdy1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_dut1 y=%b busy=%b done=%b rdy=%b exp y=0000 busy=0 done=0 rdy=1", y1, busy1, done1, rdy1);
        end
        checks++;
        if (y2 !== 4'b0000 || busy2 !== 1'b0 || done2 !== 1'b0 || rdy2 !== 1'b1) begin
            errors++;
            $display("FAIL reset_dut2 y=%b busy=%b done=%b rdy=%b exp y=0000 busy=0 done=0 rdy=1", y2, busy2, done2, rdy2);
        end
        rst = 1'b0;
        // first edge after rst falls must already accept
        req_valid = 1'b1; a = 2'd1; mode = 1'b0;
        tick();
        req_valid = 1'b0;
        checks++;
        if (y1 !== 4'b0010 || done1 !== 1'b1) begin
            errors++;
            $display("FAIL first_accept y=%b done=%b exp y=0010 done=1", y1, done1);
        end
        settle();
    endtask

    task automatic test_single();
        req_valid = 1'b1; a = 2'd2; mode = 1'b0;
        tick();
        req_valid = 1'b0;
        checks++;
        if (y2 !== 4'b0100 || busy2 !== 1'b1 || done2 !== 1'b0 || rdy2 !== 1'b0) begin
            errors++;
            $display("FAIL single_c1 y=%b busy=%b done=%b rdy=%b exp y=0100 busy=1 done=0 rdy=0", y2, busy2, done2, rdy2);
        end
        tick();
        checks++;
        if (y2 !== 4'b0100 || busy2 !== 1'b1 || done2 !== 1'b1) begin
            errors++;
            $display("FAIL single_c2 y=%b busy=%b done=%b exp y=0100 busy=1 done=1", y2, busy2, done2);
        end
        tick();
        checks++;
        if (y2 !== 4'b0000 || busy2 !== 1'b0 || done2 !== 1'b0 || rdy2 !== 1'b1) begin
            errors++;
            $display("FAIL single_c3 y=%b busy=%b done=%b rdy=%b exp y=0000 busy=0 done=0 rdy=1", y2, busy2, done2, rdy2);
        end
        settle();
    endtask

    task automatic test_scan_dwell1();
        logic [3:0] exp_y [4] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};
        req_valid = 1'b1; a = 2'd3; mode = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (y1 !== exp_y[i] || busy1 !== 1'b1 || done1 !== (i == 3)) begin
                errors++;
                $display("FAIL scan1_c%0d y=%b busy=%b done=%b exp y=%b busy=1 done=%b", i + 1, y1, busy1, done1, exp_y[i], (i == 3));
            end
            tick();
        end
        checks++;
        if (y1 !== 4'b0000 || busy1 !== 1'b0 || rdy1 !== 1'b1) begin
            errors++;
            $display("FAIL scan1_end y=%b busy=%b rdy=%b exp y=0000 busy=0 rdy=1", y1, busy1, rdy1);
        end
        settle();
    endtask

    task automatic test_scan_en();
        logic [3:0] exp_y [8] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000,
                                  4'b0100, 4'b0100, 4'b1000, 4'b1000};
        req_valid = 1'b1; a = 2'd0; mode = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            en = !(c == 3 || c == 4);
            #1;
            checks++;
            if (y2 !== exp_y[c-1] || busy2 !== 1'b1 || done2 !== (c == 8)) begin
                errors++;
                $display("FAIL scan_en_c%0d y=%b busy=%b done=%b exp y=%b busy=1 done=%b", c, y2, busy2, done2, exp_y[c-1], (c == 8));
            end
            tick();
        end
        checks++;
        if (y2 !== 4'b0000 || busy2 !== 1'b0 || done2 !== 1'b0 || rdy2 !== 1'b1) begin
            errors++;
            $display("FAIL scan_en_end y=%b busy=%b done=%b rdy=%b exp y=0000 busy=0 done=0 rdy=1", y2, busy2, done2, rdy2);
        end
        settle();
    endtask

    task automatic test_abort();
        req_valid = 1'b1; a = 2'd1; mode = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        abort = 1'b1;
        checks++;
        if (y2 !== 4'b0010 || busy2 !== 1'b1 || done2 !== 1'b0) begin
            errors++;
            $display("FAIL abort_c2 y=%b busy=%b done=%b exp y=0010 busy=1 done=0", y2, busy2, done2);
        end
        req_valid = 1'b1; a = 2'd2; mode = 1'b0;
        tick();
        checks++;
        if (y2 !== 4'b0000 || busy2 !== 1'b0 || done2 !== 1'b0 || y1 !== 4'b0000 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL abort_next y2=%b busy2=%b done2=%b y1=%b busy1=%b exp all 0", y2, busy2, done2, y1, busy1);
        end
        tick();
        checks++;
        if (busy1 !== 1'b0 || rdy1 !== 1'b1 || busy2 !== 1'b0 || rdy2 !== 1'b1 || done2 !== 1'b0) begin
            errors++;
            $display("FAIL abort_vs_req busy1=%b rdy1=%b busy2=%b rdy2=%b done2=%b exp busy=0 rdy=1 done=0", busy1, rdy1, busy2, rdy2, done2);
        end
        settle();
    endtask

    task automatic test_ignore_busy();
        logic [3:0] exp_y [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        req_valid = 1'b1; a = 2'd0; mode = 1'b1;
        tick();
        a = 2'd1; mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) req_valid = 1'b0;
            checks++;
            if (y1 !== exp_y[i] || done1 !== (i == 3)) begin
                errors++;
                $display("FAIL ignore_c%0d y=%b done=%b exp y=%b done=%b", i + 1, y1, done1, exp_y[i], (i == 3));
            end
            tick();
        end
        checks++;
        if (y1 !== 4'b0000 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL ignore_end y=%b busy=%b exp y=0000 busy=0", y1, busy1);
        end
        settle();
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; a = 2'd1; mode = 1'b0;
        tick();
        a = 2'd3;
        checks++;
        if (y1 !== 4'b0010 || done1 !== 1'b1 || rdy1 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_c1 y=%b done=%b rdy=%b exp y=0010 done=1 rdy=0", y1, done1, rdy1);
        end
        tick();
        checks++;
        if (y1 !== 4'b0000 || rdy1 !== 1'b1 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap y=%b rdy=%b busy=%b exp y=0000 rdy=1 busy=0", y1, rdy1, busy1);
        end
        tick();
        req_valid = 1'b0;
        checks++;
        if (y1 !== 4'b1000 || done1 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_c3 y=%b done=%b exp y=1000 done=1", y1, done1);
        end
        settle();
    endtask

    task automatic test_rst_mid();
        int done_seen = 0;
        req_valid = 1'b1; a = 2'd2; mode = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (y2 !== 4'b0000 || busy2 !== 1'b0 || done2 !== 1'b0 || rdy2 !== 1'b1) begin
            errors++;
            $display("FAIL rst_async y=%b busy=%b done=%b rdy=%b exp y=0000 busy=0 done=0 rdy=1", y2, busy2, done2, rdy2);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done2 !== 1'b0 || busy2 !== 1'b0) done_seen++;
            tick();
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL rst_no_done cycles_active=%0d exp 0", done_seen);
        end
        req_valid = 1'b1; a = 2'd3; mode = 1'b0;
        tick();
        req_valid = 1'b0;
        checks++;
        if (y2 !== 4'b1000 || busy2 !== 1'b1 || done2 !== 1'b0) begin
            errors++;
            $display("FAIL rst_reaccept y=%b busy=%b done=%b exp y=1000 busy=1 done=0", y2, busy2, done2);
        end
        settle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_scan_dwell1();
        test_scan_en();
        test_abort();
        test_ignore_busy();
        test_back_to_back();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/decoder_scan.md
DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 Parameter N, default 2, index width; channel count M = 2**N.
REQ-002 Parameter DWELL, default 1, cycles each channel stays selected; legal range >= 1.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 a  input  N  start channel index, sampled at accept.
REQ-009 mode  input  1  sampled at accept; 0 = SINGLE, 1 = SCAN.
REQ-010 abort  input  1  synchronous cancel of the current operation.
REQ-011 en  input  1  output enable; combinational gate on y only.
REQ-012 y  output  M  one-hot channel select; all zero when idle.
REQ-013 busy  output  1  high while an operation is in progress.
REQ-014 done  output  1  single-cycle completion pulse.

Function
REQ-015 States SHALL be IDLE, SINGLE and SCAN; req_ready = (state == IDLE).
REQ-016 Accept SHALL occur on a rising edge with req_valid && req_ready && !abort; it latches a and mode and moves to SINGLE or SCAN.
REQ-017 Latency: y SHALL show the one-hot of a in the first cycle after accept.
REQ-018 SINGLE SHALL hold one-hot(a) for DWELL cycles, then return to IDLE.
REQ-019 SCAN SHALL select a, a+1, ... mod M, each for DWELL cycles, visiting exactly M channels; the index wraps from M-1 to 0.
REQ-020 SCAN SHALL end on channel (a-1) mod M and take M*DWELL cycles in total.
REQ-021 done SHALL be high in the final dwell cycle of the last channel only.
REQ-022 In the cycle after done, state SHALL be IDLE, y = 0 and req_ready = 1.
REQ-023 busy SHALL be high in every SINGLE or SCAN cycle.
REQ-024 req_valid while busy SHALL be ignored; no queueing.
REQ-025 abort while busy SHALL give IDLE on the next edge, with y = 0 and no done pulse.
REQ-026 abort together with req_valid in IDLE SHALL win; no accept.
REQ-027 abort in the done cycle SHALL still give IDLE; done is already emitted.
REQ-028 en = 0 SHALL force y = 0 in the same cycle; sequencing, busy and done timing are unaffected.
REQ-029 The dwell counter SHALL be $clog2(DWELL+1) bits wide.
REQ-030 The channel counter SHALL be N+1 bits wide so that the count of M visited channels is representable.

Reset
REQ-031 While rst is high: state = IDLE, y = 0, busy = 0, done = 0, req_ready = 1, all counters = 0; effective immediately, without a clock.
REQ-032 Reset asserted mid-operation SHALL discard the operation; no done pulse follows reset release.
REQ-033 The first accept SHALL be possible on the first rising edge after rst falls.

Structure
REQ-034 Package decoder_scan_pkg SHALL hold the state enum typedef (IDLE, SINGLE, SCAN) and the mode enum typedef (MODE_SINGLE, MODE_SCAN).
REQ-035 One-hot generation SHALL reuse the existing combinational decoder_generic #(.N(N)) as the single sub-module.
REQ-036 All state SHALL sit in one always_ff block with async reset; output gating SHALL be in always_comb.

Verification (N=2)
REQ-037 SINGLE, DWELL=2, a=2 accepted at edge k -> y=0100 in cycles k+1..k+2, done at k+2, y=0000 and req_ready=1 at k+3.
REQ-038 SCAN, DWELL=1, a=3 -> y = 1000, 0001, 0010, 0100; done with 0100; busy high for 4 cycles.
REQ-039 SCAN, DWELL=2, a=0, en=0 for cycles 3-4 -> y=0000 in those cycles only; done still in cycle 8.
REQ-040 abort in cycle 2 of SCAN -> next cycle y=0, busy=0, no done; abort+req_valid in IDLE -> no accept.
REQ-041 req_valid with a=1 held during a busy SCAN -> ignored; completion matches the original request.
REQ-042 rst pulsed mid-SCAN between edges -> y, busy, done go to 0 immediately; no done after release; next request accepted normally.
